// File: rtl/add32_share_ctrl.sv
// 32-bit add/subtract for two requesters, computed in two halves on a shared
// external 16-bit adder. One transaction at a time, round-robin arbitration.
module add32_share_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_sub,
  output logic [1:0]  req_ready,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovf
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        sub_q, sub_d;
  logic        carry_q, carry_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_sum_q, rsp_sum_d;
  logic        rsp_cout_q, rsp_cout_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic [1:0]  grant;
  logic        accept;
  logic        win_id;

  // One-hot grant; on contention the pointer picks the winner.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept = |grant;
  assign win_id = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      sub_q      <= sub_d;
      carry_q    <= carry_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and per-half result accumulation.
  always_comb begin
    ptr_d      = ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sub_d      = sub_q;
    carry_d    = carry_q;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ptr_d    = ~win_id;
          sub_d    = req_sub[win_id];
          rsp_id_d = win_id;
          op_a_d   = win_id ? req_a1 : req_a0;
          op_b_d   = win_id ? req_b1 : req_b0;
          if (req_sub[win_id]) op_b_d = ~op_b_d;
        end
      end
      LO: begin
        rsp_sum_d[15:0] = add_sum;
        carry_d         = add_cout;
      end
      HI: begin
        rsp_sum_d[31:16] = add_sum;
        rsp_cout_d       = add_cout;
        rsp_ovf_d        = (op_a_q[31] == op_b_q[31]) && (add_sum[15] != op_a_q[31]);
      end
      default: ;
    endcase
  end

  always_comb begin
    add_a   = 16'h0000;
    add_b   = 16'h0000;
    add_cin = 1'b0;
    unique case (state_q)
      LO: begin
        add_a   = op_a_q[15:0];
        add_b   = op_b_q[15:0];
        add_cin = sub_q;
      end
      HI: begin
        add_a   = op_a_q[31:16];
        add_b   = op_b_q[31:16];
        add_cin = carry_q;
      end
      default: ;
    endcase
  end

  assign req_ready = grant;
  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: doc/add32_share_ctrl.md
ADD32_SHARE_CTRL -- requirements
Module: add32_share_ctrl

Interface
REQ-001 Parameter: none; widths fixed (operands 32 bits, shared adder 16 bits).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_a0, req_b0 / req_a1, req_b1  input  32 each  operands of requester 0 / 1.
REQ-006 req_sub  input  2  per-requester op: 0 = a+b, 1 = a-b.
REQ-007 req_ready  output  2  per-requester accept; request i accepted on an edge where req_valid[i] & req_ready[i].
REQ-008 add_a, add_b  output  16 each  operands driven to the external 16-bit ripple-carry adder.
REQ-009 add_cin  output  1  carry-in driven to the external adder.
REQ-010 add_sum  input  16  combinational sum from the external adder.
REQ-011 add_cout  input  1  combinational carry-out from the external adder.
REQ-012 rsp_valid  output  1  result valid.
REQ-013 rsp_ready  input  1  consumer accepts result when rsp_valid & rsp_ready.
REQ-014 rsp_id  output  1  index of requester that owns the result.
REQ-015 rsp_sum  output  32  32-bit result.
REQ-016 rsp_cout  output  1  carry-out of bit 31 (for sub: 1 = no borrow).
REQ-017 rsp_ovf  output  1  signed overflow of the 32-bit operation.

Function
REQ-018 FSM states IDLE, LO, HI, DONE; only one transaction in flight.
REQ-019 req_ready SHALL be combinational: nonzero only in IDLE, at most one bit set (one-hot grant).
REQ-020 Grant in IDLE: single valid requester wins; both valid -> requester at priority pointer wins.
REQ-021 Priority pointer toggles to the non-winning requester on each acceptance; unchanged otherwise.
REQ-022 Acceptance edge k: capture a, b (b inverted if sub), sub flag, id; IDLE -> LO.
REQ-023 LO cycle: add_a = a[15:0], add_b = b'[15:0], add_cin = sub; edge k+1 registers add_sum as result[15:0], add_cout as internal carry; LO -> HI.
REQ-024 HI cycle: add_a = a[31:16], add_b = b'[31:16], add_cin = registered carry; edge k+2 registers result[31:16], rsp_cout = add_cout, rsp_ovf = (a[31]==b'[31]) & (sum[31]!=a[31]); HI -> DONE.
REQ-025 In IDLE and DONE add_a, add_b, add_cin SHALL be driven to 0.
REQ-026 DONE: rsp_valid = 1; rsp_id/rsp_sum/rsp_cout/rsp_ovf stable until handshake.
REQ-027 DONE with rsp_ready = 1 -> IDLE on that edge; rsp_valid low next cycle; earliest next acceptance one cycle later (throughput 1 op / 4 cycles).
REQ-028 DONE with rsp_ready = 0 -> hold DONE indefinitely; req_ready stays 0.
REQ-029 Latency: rsp_valid first high in the cycle after edge k+2 (3 edges after acceptance).
REQ-030 Dropping req_valid before acceptance is legal and has no effect; operand changes after acceptance have no effect.
REQ-031 Arithmetic wraps modulo 2^32; no saturation.

Reset
REQ-032 rst_n low, asynchronously: state IDLE, pointer = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, rsp_ovf = 0, internal carry = 0, add_* = 0.
REQ-033 Reset in LO/HI/DONE discards the transaction; no response is produced after reset release.

Verification
REQ-034 Req0 add 0x0000FFFF + 0x00000001 -> rsp_sum = 0x00010000, cout 0, ovf 0, id 0, 3 edges after accept (checks LO->HI carry).
REQ-035 Req1 sub 0x00000000 - 0x00000001 -> rsp_sum = 0xFFFFFFFF, cout 0, ovf 0, id 1.
REQ-036 Req0 add 0x7FFFFFFF + 0x00000001 -> 0x80000000, ovf 1; 0xFFFFFFFF + 0x00000001 -> 0x00000000, cout 1, ovf 0.
REQ-037 Both req_valid held high for 4 transactions after reset -> grants 0,1,0,1; rsp_id follows; req_ready never 2'b11.
REQ-038 rsp_ready held 0 for 5 cycles in DONE -> rsp_* stable, req_ready = 0 throughout; release -> IDLE next edge.
REQ-039 rst_n pulsed low during HI -> all outputs 0 immediately, no rsp_valid after release, next request granted to requester 0 when both valid.
